// File: rtl/dcache_responder_pkg.sv
// Shared pipeline definitions: MA control-field bit positions and the
// state encoding used by the data-side cache responder.
package pipelinedefs;

  localparam int MA_EN = 1;
  localparam int MA_RW = 0;

  typedef enum logic [1:0] {
    DC_IDLE  = 2'd0,
    DC_FILL  = 2'd1,
    DC_WRITE = 2'd2
  } dc_state_t;

endpackage

// File: rtl/dcache_responder_if.sv
// Backing-memory bus between the cache responder (master) and the
// word-wide backing memory (slave), req/ack handshake.
interface dcache_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dcache_line_store.sv
// Direct-mapped line arrays: valid/tag/data with asynchronous read and a
// single synchronous write port; valid bits clear on reset.
module dcache_line_store #(
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 26,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data
);
  localparam int LINES = 1 << IDX_W;

  logic [LINES-1:0]  valid_r;
  logic [TAG_W-1:0]  tag_r  [LINES];
  logic [DATA_W-1:0] data_r [LINES];

  assign rd_valid = valid_r[rd_idx];
  assign rd_tag   = tag_r[rd_idx];
  assign rd_data  = data_r[rd_idx];

  // Only the valid bits need clearing; stale tag/data are masked by them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= '0;
    end else if (wr_en) begin
      valid_r[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_r[wr_idx]  <= wr_tag;
      data_r[wr_idx] <= wr_data;
    end
  end
endmodule

// File: rtl/dcache_responder.sv
// MA-stage data cache responder: direct-mapped, write-through,
// no-write-allocate, one word per line, in front of a req/ack backing memory.
module dcache_responder
  import pipelinedefs::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic                 i_rw,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic [DATA_W-1:0]    i_wdata,
  output logic [DATA_W-1:0]    o_rdata,
  output logic                 o_miss,
  dcache_responder_if.master   mem,
  output logic [CNT_W-1:0]     o_hit_cnt,
  output logic [CNT_W-1:0]     o_miss_cnt
);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  dc_state_t         state_r;
  logic              mem_req_r, mem_we_r, done_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [CNT_W-1:0]  hit_cnt_r, miss_cnt_r;

  logic [IDX_W-1:0]  idx_s;
  logic [TAG_W-1:0]  tag_s, rd_tag_s;
  logic              rd_valid_s, hit_s, active_s, load_hit_s;
  logic [DATA_W-1:0] rd_data_s;
  logic              wr_en_s;
  logic [IDX_W-1:0]  wr_idx_s;
  logic [TAG_W-1:0]  wr_tag_s;
  logic [DATA_W-1:0] wr_data_s;
  logic              miss_s;

  assign idx_s = i_addr[IDX_W+1:2];
  assign tag_s = i_addr[ADDR_W-1:IDX_W+2];
  assign hit_s = i_en & rd_valid_s & (rd_tag_s == tag_s);
  // done_r suppresses re-issue of the store that has just been acknowledged.
  assign active_s   = (state_r == DC_IDLE) & i_en & ~done_r;
  assign load_hit_s = active_s & ~i_rw & hit_s;

  dcache_line_store #(.IDX_W(IDX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_lines (
    .clk(clk), .rst(rst),
    .rd_idx(idx_s), .rd_valid(rd_valid_s), .rd_tag(rd_tag_s), .rd_data(rd_data_s),
    .wr_en(wr_en_s), .wr_idx(wr_idx_s), .wr_tag(wr_tag_s), .wr_data(wr_data_s)
  );

  // Line write port: fill install on ack, or write-through update of a resident line.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_idx_s  = idx_s;
    wr_tag_s  = tag_s;
    wr_data_s = i_wdata;
    if ((state_r == DC_FILL) && mem.mem_ack) begin
      wr_en_s   = 1'b1;
      wr_idx_s  = mem_addr_r[IDX_W+1:2];
      wr_tag_s  = mem_addr_r[ADDR_W-1:IDX_W+2];
      wr_data_s = mem.mem_rdata;
    end else if (active_s && i_rw && hit_s) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Stall flag for the hazard unit.
  always_comb begin
    miss_s = 1'b0;
    case (state_r)
      DC_IDLE:  if (active_s) miss_s = i_rw | ~hit_s; else miss_s = 1'b0;
      DC_FILL:  miss_s = 1'b1;
      DC_WRITE: miss_s = 1'b1;
      default:  miss_s = 1'b1;
    endcase
  end

  assign o_miss  = miss_s;
  assign o_rdata = load_hit_s ? rd_data_s : '0;

  // Control FSM with registered backing-memory request and statistics.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= DC_IDLE;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      done_r      <= 1'b0;
      hit_cnt_r   <= '0;
      miss_cnt_r  <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        DC_IDLE: begin
          if (active_s && i_rw) begin
            state_r     <= DC_WRITE;
            mem_req_r   <= 1'b1;
            mem_we_r    <= 1'b1;
            mem_addr_r  <= {i_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_r <= i_wdata;
          end else if (active_s && !hit_s) begin
            state_r    <= DC_FILL;
            mem_req_r  <= 1'b1;
            mem_we_r   <= 1'b0;
            mem_addr_r <= {i_addr[ADDR_W-1:2], 2'b00};
            if (miss_cnt_r != CNT_MAX) miss_cnt_r <= miss_cnt_r + CNT_W'(1);
          end else if (load_hit_s) begin
            if (hit_cnt_r != CNT_MAX) hit_cnt_r <= hit_cnt_r + CNT_W'(1);
          end
        end
        DC_FILL: begin
          if (mem.mem_ack) begin
            state_r   <= DC_IDLE;
            mem_req_r <= 1'b0;
          end
        end
        DC_WRITE: begin
          if (mem.mem_ack) begin
            state_r   <= DC_IDLE;
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
            done_r    <= i_en;
          end
        end
        default: begin
          state_r   <= DC_IDLE;
          mem_req_r <= 1'b0;
          mem_we_r  <= 1'b0;
        end
      endcase
    end
  end

  assign mem.mem_req   = mem_req_r;
  assign mem.mem_we    = mem_we_r;
  assign mem.mem_addr  = mem_addr_r;
  assign mem.mem_wdata = mem_wdata_r;
  assign o_hit_cnt     = hit_cnt_r;
  assign o_miss_cnt    = miss_cnt_r;
endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: backing memory is driven by hand,
// expected values are the hand-computed results of each access.
module tb_dcache_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_en = 1'b0, i_rw = 1'b0;
  logic [31:0] i_addr = 32'd0, i_wdata = 32'd0;
  logic [31:0] o_rdata;
  logic        o_miss;
  logic [15:0] o_hit_cnt, o_miss_cnt;
  int          vec_cnt = 0, miscmp_cnt = 0;

  dcache_responder_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

  dcache_responder #(.ADDR_W(32), .DATA_W(32), .IDX_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_rw(i_rw), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_rdata(o_rdata), .o_miss(o_miss), .mem(mem_bus),
    .o_hit_cnt(o_hit_cnt), .o_miss_cnt(o_miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Present an access just after a rising edge; return at the following falling edge.
  task automatic access(input logic en, input logic rw, input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clk);
    #1;
    i_en = en; i_rw = rw; i_addr = addr; i_wdata = wdata;
    @(negedge clk);
  endtask

  // Act as backing memory: wait for req, check it for lat cycles, then ack.
  task automatic serve(input string tag, input int lat, input logic [31:0] rdata,
                       input logic exp_we, input logic [31:0] exp_addr, input logic [31:0] exp_wdata);
    int waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (mem_bus.mem_req !== 1'b1 && waited < 20);
    if (mem_bus.mem_req !== 1'b1) begin
      check_vec({tag, "_req_timeout"}, 32'(mem_bus.mem_req), 32'd1);
      return;
    end
    check_vec({tag, "_we"}, 32'(mem_bus.mem_we), 32'(exp_we));
    check_vec({tag, "_addr"}, mem_bus.mem_addr, exp_addr);
    if (exp_we) check_vec({tag, "_wdata"}, mem_bus.mem_wdata, exp_wdata);
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      check_vec({tag, "_hold_req"}, 32'(mem_bus.mem_req), 32'd1);
      check_vec({tag, "_hold_addr"}, mem_bus.mem_addr, exp_addr);
    end
    mem_bus.mem_ack = 1'b1;
    mem_bus.mem_rdata = rdata;
    @(posedge clk);
    #1;
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = 32'd0;
    @(negedge clk);
    check_vec({tag, "_req_fall"}, 32'(mem_bus.mem_req), 32'd0);
  endtask

  initial begin
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    check_vec("rst_miss", 32'(o_miss), 32'd0);
    check_vec("rst_req", 32'(mem_bus.mem_req), 32'd0);
    check_vec("rst_we", 32'(mem_bus.mem_we), 32'd0);
    check_vec("rst_addr", mem_bus.mem_addr, 32'd0);
    check_vec("rst_wdata", mem_bus.mem_wdata, 32'd0);
    check_vec("rst_rdata", o_rdata, 32'd0);
    check_vec("rst_cnts", {o_hit_cnt, o_miss_cnt}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Cold load miss, fill, then hit on the held access
    access(1'b1, 1'b0, 32'h0000_0040, 32'd0);
    check_vec("cold_miss", 32'(o_miss), 32'd1);
    serve("cold", 3, 32'hDEAD_BEEF, 1'b0, 32'h0000_0040, 32'd0);
    check_vec("cold_nomiss", 32'(o_miss), 32'd0);
    check_vec("cold_rdata", o_rdata, 32'hDEAD_BEEF);
    access(1'b0, 1'b0, 32'd0, 32'd0);
    check_vec("cold_cnts", {o_hit_cnt, o_miss_cnt}, {16'd1, 16'd1});

    // Repeat load hits in the same cycle
    access(1'b1, 1'b0, 32'h0000_0040, 32'd0);
    check_vec("rep_miss", 32'(o_miss), 32'd0);
    check_vec("rep_rdata", o_rdata, 32'hDEAD_BEEF);
    access(1'b0, 1'b0, 32'd0, 32'd0);
    check_vec("rep_req", 32'(mem_bus.mem_req), 32'd0);
    check_vec("rep_hit_cnt", 32'(o_hit_cnt), 32'd2);

    // Conflict on index 0 evicts 0x40
    access(1'b1, 1'b0, 32'h0000_0440, 32'd0);
    check_vec("conf_miss", 32'(o_miss), 32'd1);
    serve("conf", 2, 32'hCAFE_0440, 1'b0, 32'h0000_0440, 32'd0);
    check_vec("conf_rdata", o_rdata, 32'hCAFE_0440);
    access(1'b1, 1'b0, 32'h0000_0040, 32'd0);
    check_vec("refill_miss", 32'(o_miss), 32'd1);
    serve("refill", 1, 32'hDEAD_BEEF, 1'b0, 32'h0000_0040, 32'd0);
    check_vec("refill_rdata", o_rdata, 32'hDEAD_BEEF);
    access(1'b0, 1'b0, 32'd0, 32'd0);
    check_vec("conf_cnts", {o_hit_cnt, o_miss_cnt}, {16'd4, 16'd3});

    // Store hit: single write-through, then load sees new data
    access(1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678);
    check_vec("st_miss", 32'(o_miss), 32'd1);
    serve("st", 2, 32'd0, 1'b1, 32'h0000_0040, 32'h1234_5678);
    check_vec("st_done", 32'(o_miss), 32'd0);
    access(1'b1, 1'b0, 32'h0000_0040, 32'd0);
    check_vec("st_nodup", 32'(mem_bus.mem_req), 32'd0);
    check_vec("st_ld_miss", 32'(o_miss), 32'd0);
    check_vec("st_ld_rdata", o_rdata, 32'h1234_5678);

    // Store miss: written through, not allocated
    access(1'b1, 1'b1, 32'h0000_0080, 32'h55AA_55AA);
    check_vec("stm_miss", 32'(o_miss), 32'd1);
    serve("stm", 1, 32'd0, 1'b1, 32'h0000_0080, 32'h55AA_55AA);
    check_vec("stm_done", 32'(o_miss), 32'd0);
    access(1'b1, 1'b0, 32'h0000_0080, 32'd0);
    check_vec("stm_ld_miss", 32'(o_miss), 32'd1);
    serve("stm_ld", 1, 32'h55AA_55AA, 1'b0, 32'h0000_0080, 32'd0);
    check_vec("stm_ld_rdata", o_rdata, 32'h55AA_55AA);
    access(1'b0, 1'b0, 32'd0, 32'd0);
    check_vec("stm_cnts", {o_hit_cnt, o_miss_cnt}, {16'd6, 16'd4});

    // Reset in cycle 2 of a fill drops the request and invalidates lines
    access(1'b1, 1'b0, 32'h0000_00C0, 32'd0);
    check_vec("rf_miss", 32'(o_miss), 32'd1);
    @(negedge clk);
    check_vec("rf_req1", 32'(mem_bus.mem_req), 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_vec("rf_req_drop", 32'(mem_bus.mem_req), 32'd0);
    i_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    mem_bus.mem_ack = 1'b1;
    @(posedge clk);
    #1 mem_bus.mem_ack = 1'b0;
    @(negedge clk);
    check_vec("rf_stale_req", 32'(mem_bus.mem_req), 32'd0);
    check_vec("rf_stale_miss", 32'(o_miss), 32'd0);
    check_vec("rf_cnts", {o_hit_cnt, o_miss_cnt}, 32'd0);
    access(1'b1, 1'b0, 32'h0000_0040, 32'd0);
    check_vec("rf_ld_miss", 32'(o_miss), 32'd1);
    serve("rf_ld", 2, 32'hA5A5_0040, 1'b0, 32'h0000_0040, 32'd0);
    check_vec("rf_ld_rdata", o_rdata, 32'hA5A5_0040);
    check_vec("rf_ld_cnts", {o_hit_cnt, o_miss_cnt}, {16'd0, 16'd1});
    access(1'b0, 1'b0, 32'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end
endmodule
